mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- Generalised memory-access pipeline stage between EX and WB.
- Issues load/store requests on a split request/response (addr_ok/data_ok) data bus.
- Tracks up to OUTST in-flight instructions in an in-order queue and retires them to WB in program order.
- Performs store byte-lane/strobe generation and load alignment plus sign/zero extension for DATA_W of 32 or 64.

Parameters:
- DATA_W, 32, data bus width; legal values 32 or 64.
- ADDR_W, 32, address width.
- OUTST, 2, in-flight queue depth; legal range 1..4.
- RESET_PC, 32'h1c000000, pc_out value while the queue is empty.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  EX→MEM valid.
- in_ready  out  1  MEM accepts the EX instruction this cycle.
- out_valid  out  1  MEM→WB valid.
- out_ready  in  1  WB accepts.
- flush  in  1  drop all queued and incoming instructions.
- pc  in  32  instruction PC.
- result  in  ADDR_W  ALU result; effective address for memory ops.
- load_op  in  8  one-hot: [0]LD.B [1]LD.H [2]LD.W [3]LD.BU [4]LD.HU [5]ST.B [6]ST.H [7]ST.W.
- gr_we  in  1  register write enable.
- dest  in  5  destination register.
- rkd_value  in  32  store data.
- data_req  out  1  bus request.
- data_wr  out  1  1 = store.
- data_size  out  2  0 = byte, 1 = half, 2 = word.
- data_wstrb  out  DATA_W/8  byte strobes.
- data_addr  out  ADDR_W  request address; low log2(DATA_W/8) bits cleared.
- data_wdata  out  DATA_W  lane-replicated store data.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  response, one per request, in order.
- data_rdata  in  DATA_W  load data.
- pc_out  out  32  retired PC.
- result_out  out  32  final write-back value.
- gr_we_out  out  1  retired register write enable.
- dest_out  out  5  retired destination.
- ale_out  out  1  misaligned-access flag.

Behaviour:
- Reset: when rst_n=0 at posedge clk, the queue is emptied and the discard counter is zeroed. Outputs while empty: out_valid=0, pc_out=RESET_PC, result_out=0, gr_we_out=0, dest_out=0, ale_out=0. Reset during outstanding requests drops them, because the memory is reset together with this stage.
- mem op: any of load_op[7:0] set. Non-mem ops bypass the bus.
- space: count<OUTST, or the head retires this cycle (pop before push).
- data_req = rst_n & in_valid & mem op & space & !flush.
- in_ready = rst_n & !flush & (!in_valid | space & (!mem op | data_addr_ok)).
- Push: on in_valid&in_ready, store {pc, result, load_op, gr_we, dest, need=mem op, got=0} in the entry.
- Response: data_data_ok while discard>0 decrements discard and is otherwise ignored. Otherwise it marks the oldest entry with need&!got as got=1 and latches data_rdata. A data_data_ok with no such entry is a protocol error; assertion only.
- Head ready: !need | got; out_valid = head valid & head ready. Pop on out_valid&out_ready. Latency: non-mem op to out_valid is 1 cycle; mem op is 1 cycle after data_ok at the earliest.
- Store: the strobe is shifted by the low address bits.
  - ST.B: strobe 1 at byte offset; data byte replicated across all lanes.
  - ST.H: strobe 2'b11 at offset; halfword replicated.
  - ST.W: strobe 4'hF at word offset; word replicated.
  - Stores retire with result_out=result.
- Load: select the addressed byte/half/word lane from the latched rdata. LD.B/LD.H sign-extend; LD.BU/LD.HU zero-extend. result_out = the extended value.
- Flush: all entries are removed the same cycle. discard += the number of entries with need&!got, minus 1 if data_data_ok consumes one that same cycle. The next out_valid comes only from instructions pushed after the flush. No new request while flush=1.
- Simultaneous push, pop and data_ok are all legal in one cycle. Count stays at OUTST when the queue is full and the head pops.
- Full queue: in_ready=0 and data_req=0 until the head retires.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - A half access with addr[0]=1 or a word access with addr[1:0]≠0 issues no request.
  - The instruction is pushed with need=0, ale=1 and retires with gr_we_out=0 and ale_out=1.
- Undefined:
  - ale_out is constant 0.
  - Misaligned low address bits are truncated to the access size.

Test Plan:
- Reset with rst_n=0 for 2 cycles, then release → out_valid=0, pc_out=32'h1c000000, data_req=0.
- ST.B with rkd_value=32'h12345678 and result=32'h1000_0003, DATA_W=32 → data_wstrb=4'b1000, data_wdata=32'h78787878, data_addr=32'h1000_0000.
- LD.B at result=…02 with data_rdata=32'h0080_0000, data_ok 3 cycles after addr_ok → out_valid 1 cycle after data_ok, result_out=32'hFFFF_FF80. LD.BU gives 32'h0000_0080.
- OUTST=2: three back-to-back loads with data_ok withheld → third in_ready=0. Two data_ok pulses → retirement in PC order.
- Flush with 2 outstanding loads, then an ADD → both later data_ok pulses are discarded. ADD retires with its result, no stale load data.
- With MEM_ALIGN_CHECK_EN, LD.W at result=…02 → data_req=0, ale_out=1, gr_we_out=0.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: EX->WB memory-access stage with an in-order queue of
// in-flight instructions, a split addr_ok/data_ok bus, store lane/strobe
// generation and load alignment with sign/zero extension.
// Optional misaligned-access detection: define MEM_ALIGN_CHECK_EN.
module mem_access_stage #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned OUTST    = 2,
   parameter logic [31:0] RESET_PC = 32'h1c000000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   output logic                out_valid,
   input  logic                out_ready,
   input  logic                flush,
   input  logic [31:0]         pc,
   input  logic [ADDR_W-1:0]   result,
   input  logic [7:0]          load_op,
   input  logic                gr_we,
   input  logic [4:0]          dest,
   input  logic [31:0]         rkd_value,
   output logic                data_req,
   output logic                data_wr,
   output logic [1:0]          data_size,
   output logic [DATA_W/8-1:0] data_wstrb,
   output logic [ADDR_W-1:0]   data_addr,
   output logic [DATA_W-1:0]   data_wdata,
   input  logic                data_addr_ok,
   input  logic                data_data_ok,
   input  logic [DATA_W-1:0]   data_rdata,
   output logic [31:0]         pc_out,
   output logic [31:0]         result_out,
   output logic                gr_we_out,
   output logic [4:0]          dest_out,
   output logic                ale_out
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned OFF_W  = $clog2(STRB_W);
   localparam int unsigned CNT_W  = $clog2(OUTST + 1);
   localparam int unsigned DISC_W = 4;

   // One in-flight instruction; lop keeps only the load bits needed at retire.
   typedef struct packed {
      logic [31:0]       pc;
      logic [ADDR_W-1:0] result;
      logic [4:0]        lop;
      logic              gr_we;
      logic [4:0]        dest;
      logic              need;
      logic              got;
      logic              ale;
      logic [DATA_W-1:0] rdata;
   } entry_t;

   entry_t            ent_q [OUTST];
   entry_t            ent_w [OUTST];
   entry_t            ent_d [OUTST];
   entry_t            new_ent_c;
   entry_t            head_c;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  push_pos_c;
   logic [DISC_W-1:0] disc_q, disc_d;
   logic [DISC_W-1:0] pend_c;

   logic              is_mem_c, bus_op_c, mis_c, space_c;
   logic              push_c, pop_c, drop_c, hit_c;
   logic              st_b_c, st_h_c, st_w_c, acc_half_c, acc_word_c;
   logic [OFF_W-1:0]  off_c, h_off_c;
   logic              head_vld_c;
   logic [7:0]        ld_byte_c;
   logic [15:0]       ld_half_c;
   logic [31:0]       ld_word_c;

   // Request-side decode of the incoming EX instruction
   assign is_mem_c   = |load_op;
   assign off_c      = result[OFF_W-1:0];
   assign st_b_c     = load_op[5];
   assign st_h_c     = load_op[6];
   assign st_w_c     = load_op[7];
   assign acc_half_c = load_op[1] | load_op[4] | st_h_c;
   assign acc_word_c = load_op[2] | st_w_c;

`ifdef MEM_ALIGN_CHECK_EN
   assign mis_c = (acc_half_c & off_c[0]) | (acc_word_c & (off_c[1:0] != 2'b00));
`else
   assign mis_c = 1'b0;
`endif

   assign bus_op_c = is_mem_c & ~mis_c;

   // Queue head and handshakes; a retiring head frees its slot this cycle
   assign head_c     = ent_q[0];
   assign head_vld_c = (cnt_q != '0);
   assign out_valid  = head_vld_c & (~head_c.need | head_c.got);
   assign pop_c      = out_valid & out_ready;
   assign space_c    = (cnt_q < CNT_W'(OUTST)) | pop_c;
   assign data_req   = rst_n & in_valid & bus_op_c & space_c & ~flush;
   assign in_ready   = rst_n & ~flush & (~in_valid | (space_c & (~bus_op_c | data_addr_ok)));
   assign push_c     = in_valid & in_ready;
   assign data_addr  = {result[ADDR_W-1:OFF_W], OFF_W'(0)};
   assign data_wr    = st_b_c | st_h_c | st_w_c;

   // Store strobe/lane replication and access size
   always_comb begin
      data_wstrb = '0;
      data_wdata = '0;
      data_size  = 2'd0;
      if (acc_word_c) begin
         data_size = 2'd2;
      end else if (acc_half_c) begin
         data_size = 2'd1;
      end
      if (st_b_c) begin
         data_wstrb = STRB_W'(1) << off_c;
         data_wdata = {STRB_W{rkd_value[7:0]}};
      end else if (st_h_c) begin
         data_wstrb = STRB_W'(2'b11) << (off_c & ~OFF_W'(1));
         data_wdata = {(DATA_W/16){rkd_value[15:0]}};
      end else if (st_w_c) begin
         data_wstrb = STRB_W'(4'hF) << (off_c & ~OFF_W'(3));
         data_wdata = {(DATA_W/32){rkd_value}};
      end
   end

   // Entry written on push
   always_comb begin
      new_ent_c        = '0;
      new_ent_c.pc     = pc;
      new_ent_c.result = result;
      new_ent_c.lop    = load_op[4:0];
      new_ent_c.gr_we  = gr_we;
      new_ent_c.dest   = dest;
      new_ent_c.need   = bus_op_c;
      new_ent_c.ale    = mis_c;
   end

   // Response capture, flush accounting, pop-shift and push
   always_comb begin
      ent_w  = ent_q;
      hit_c  = 1'b0;
      pend_c = '0;
      drop_c = data_data_ok & (disc_q != '0);
      for (int i = 0; i < int'(OUTST); i++) begin
         if ((CNT_W'(i) < cnt_q) && ent_q[i].need && !ent_q[i].got) begin
            pend_c = pend_c + DISC_W'(1);
            if (!hit_c && data_data_ok && !drop_c) begin
               ent_w[i].got   = 1'b1;
               ent_w[i].rdata = data_rdata;
               hit_c          = 1'b1;
            end
         end
      end

      ent_d = ent_w;
      if (pop_c) begin
         for (int i = 0; i < int'(OUTST) - 1; i++) begin
            ent_d[i] = ent_w[i+1];
         end
      end
      push_pos_c = cnt_q - CNT_W'(pop_c);
      for (int i = 0; i < int'(OUTST); i++) begin
         if (push_c && (CNT_W'(i) == push_pos_c)) begin
            ent_d[i] = new_ent_c;
         end
      end

      cnt_d  = cnt_q - CNT_W'(pop_c) + CNT_W'(push_c);
      disc_d = disc_q - DISC_W'(drop_c);
      if (flush) begin
         cnt_d  = '0;
         disc_d = disc_q + pend_c - DISC_W'(drop_c) - DISC_W'(hit_c);
      end
   end

   // Queue occupancy and discard counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         disc_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         disc_q <= disc_d;
      end
   end

   // Entry payload storage; validity is carried by cnt_q
   always_ff @(posedge clk) begin
      ent_q <= ent_d;
   end

   // Load lane selection from the head's latched read data
   always_comb begin
      h_off_c   = head_c.result[OFF_W-1:0];
      ld_byte_c = 8'(head_c.rdata >> {h_off_c, 3'b000});
      ld_half_c = 16'(head_c.rdata >> {h_off_c & ~OFF_W'(1), 3'b000});
      ld_word_c = 32'(head_c.rdata >> {h_off_c & ~OFF_W'(3), 3'b000});
   end

   // Retire-side outputs, idle values while the queue is empty
   always_comb begin
      pc_out     = RESET_PC;
      result_out = '0;
      gr_we_out  = 1'b0;
      dest_out   = '0;
      if (head_vld_c) begin
         pc_out    = head_c.pc;
         gr_we_out = head_c.gr_we & ~head_c.ale;
         dest_out  = head_c.dest;
         if (head_c.lop[0]) begin
            result_out = {{24{ld_byte_c[7]}}, ld_byte_c};
         end else if (head_c.lop[3]) begin
            result_out = {24'd0, ld_byte_c};
         end else if (head_c.lop[1]) begin
            result_out = {{16{ld_half_c[15]}}, ld_half_c};
         end else if (head_c.lop[4]) begin
            result_out = {16'd0, ld_half_c};
         end else if (head_c.lop[2]) begin
            result_out = ld_word_c;
         end else begin
            result_out = 32'(head_c.result);
         end
      end
   end

`ifdef MEM_ALIGN_CHECK_EN
   assign ale_out = head_vld_c & head_c.ale;
`else
   assign ale_out = 1'b0;
`endif

   // Every response must belong to a discarded or a waiting request
   a_resp_owner: assert property (@(posedge clk) disable iff (!rst_n)
      data_data_ok |-> ((disc_q != '0) || (pend_c != '0)));

endmodule
